// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, FSM encoding and dispatch helper for alu_seq_unit
package alu_seq_pkg;

  localparam logic [3:0] OP_ORA = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_EOR = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_SBC = 4'd4;
  localparam logic [3:0] OP_ROR = 4'd5;
  localparam logic [3:0] OP_ROL = 4'd6;
  localparam logic [3:0] OP_PSA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Divide by zero short-circuits straight to DONE with the fixed all-ones result.
  function automatic logic needs_run(input logic [3:0] op, input logic b_is_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_is_zero);
  endfunction

endpackage

// File: rtl/alu_bcd_adder.sv
// rtl/alu_bcd_adder.sv - combinational binary adder with per-digit decimal correction
// b arrives already inverted for subtraction; sub selects the subtract-style digit fixup.
module alu_bcd_adder #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = WIDTH / 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             dec,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             half_carry_out,
  output logic             overflow_out
);

  logic [WIDTH:0]   bin;
  logic [4:0]       low_nib;
  logic [WIDTH-1:0] dsum;
  logic             dc;
  logic [4:0]       ds;

  assign bin     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
  assign low_nib = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, c_in};

  // Digit carry ripples low to high; for subtract it is the plain binary digit carry.
  always_comb begin
    dsum = '0;
    dc   = c_in;
    ds   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ds = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, dc};
      if (sub) begin
        dsum[4*i +: 4] = ds[4] ? ds[3:0] : ds[3:0] - 4'd6;
        dc             = ds[4];
      end else if (ds > 5'd9) begin
        dsum[4*i +: 4] = ds[3:0] + 4'd6;
        dc             = 1'b1;
      end else begin
        dsum[4*i +: 4] = ds[3:0];
        dc             = 1'b0;
      end
    end
  end

  assign sum            = dec ? dsum : bin[WIDTH-1:0];
  assign carry_out      = dec ? dc : bin[WIDTH];
  assign half_carry_out = low_nib[4];
  assign overflow_out   = (a[WIDTH-1] == b[WIDTH-1]) && (bin[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - registered 65xx-style ALU with iterative unsigned MUL/DIV
// Results and flags are written once, in DONE, and held until the next DONE.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = WIDTH / 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             dec,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             half_carry_out,
  output logic             overflow_out,
  output logic             zero_out,
  output logic             negative_out,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic             c_r, dec_r;
  logic [WIDTH-1:0] acc_hi, acc_lo;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_ci, add_dec, add_sub;
  logic             add_co, add_hc, add_v;

  logic [WIDTH:0]   mul_sum;
  logic             div_ok;

  logic [WIDTH-1:0] n_res, n_hi;
  logic             n_c, n_v, n_hc, n_z, n_n, n_dz;

  assign busy = (state != ST_IDLE);

  // During RUN the adder performs the restoring trial subtraction of the divisor.
  always_comb begin
    add_a   = a_r;
    add_b   = b_r;
    add_ci  = c_r;
    add_dec = dec_r;
    add_sub = 1'b0;
    if (state == ST_RUN) begin
      add_a   = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      add_b   = ~b_r;
      add_ci  = 1'b1;
      add_dec = 1'b0;
      add_sub = 1'b1;
    end else if (op_r == OP_SBC) begin
      add_b   = ~b_r;
      add_sub = 1'b1;
    end
  end

  alu_bcd_adder #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_adder (
    .a              (add_a),
    .b              (add_b),
    .c_in           (add_ci),
    .dec            (add_dec),
    .sub            (add_sub),
    .sum            (add_sum),
    .carry_out      (add_co),
    .half_carry_out (add_hc),
    .overflow_out   (add_v)
  );

  // Shifted remainder is WIDTH+1 bits; its top bit alone guarantees the subtract fits.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
  assign div_ok  = acc_hi[WIDTH-1] | add_co;

  always_comb begin
    n_res = a_r;
    n_hi  = '0;
    n_c   = 1'b0;
    n_v   = 1'b0;
    n_hc  = 1'b0;
    n_dz  = div_zero;
    case (op_r)
      OP_ORA: n_res = a_r | b_r;
      OP_AND: begin
        n_res = a_r & b_r;
        n_c   = |(a_r & b_r);
      end
      OP_EOR: n_res = a_r ^ b_r;
      OP_ADC, OP_SBC: begin
        n_res = add_sum;
        n_c   = add_co;
        n_v   = add_v;
        n_hc  = add_hc;
      end
      OP_ROR: begin
        n_res = {c_r, a_r[WIDTH-1:1]};
        n_c   = a_r[0];
      end
      OP_ROL: begin
        n_res = {a_r[WIDTH-2:0], c_r};
        n_c   = a_r[WIDTH-1];
      end
      OP_MUL: begin
        n_res = acc_lo;
        n_hi  = acc_hi;
      end
      OP_DIV: begin
        if (b_r == '0) begin
          n_res = '1;
          n_hi  = a_r;
          n_dz  = 1'b1;
          n_c   = 1'b1;
        end else begin
          n_res = acc_lo;
          n_hi  = acc_hi;
          n_dz  = 1'b0;
        end
      end
      default: n_res = a_r;
    endcase
    n_z = (op_r == OP_MUL) ? ({n_hi, n_res} == '0) : (n_res == '0);
    n_n = (op_r == OP_MUL) ? n_hi[WIDTH-1] : n_res[WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      op_r           <= '0;
      a_r            <= '0;
      b_r            <= '0;
      c_r            <= 1'b0;
      dec_r          <= 1'b0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      done           <= 1'b0;
      result         <= '0;
      result_hi      <= '0;
      carry_out      <= 1'b0;
      half_carry_out <= 1'b0;
      overflow_out   <= 1'b0;
      zero_out       <= 1'b0;
      negative_out   <= 1'b0;
      div_zero       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r   <= op;
            a_r    <= a;
            b_r    <= b;
            c_r    <= c_in;
            dec_r  <= dec;
            acc_hi <= '0;
            acc_lo <= (op == OP_MUL) ? b : a;
            cnt    <= '0;
            state  <= needs_run(op, b == '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (op_r == OP_MUL) begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end else begin
            acc_hi <= div_ok ? add_sum : add_a;
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          result         <= n_res;
          result_hi      <= n_hi;
          carry_out      <= n_c;
          half_carry_out <= n_hc;
          overflow_out   <= n_v;
          zero_out       <= n_z;
          negative_out   <= n_n;
          div_zero       <= n_dz;
          done           <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - scoreboard bench for alu_seq_unit at WIDTH=8 and WIDTH=16
module tb_alu_seq_unit;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic       s8, c8, dc8;
  logic [3:0] op8;
  logic [7:0] a8, b8;
  logic       busy8, done8, co8, hc8, v8, z8, n8, dz8;
  logic [7:0] res8, hi8;

  logic        s16, c16, dc16;
  logic [3:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, done16, co16, hc16, v16, z16, n16, dz16;
  logic [15:0] res16, hi16;

  alu_seq_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(s8), .op(op8), .a(a8), .b(b8),
    .c_in(c8), .dec(dc8), .busy(busy8), .done(done8), .result(res8),
    .result_hi(hi8), .carry_out(co8), .half_carry_out(hc8),
    .overflow_out(v8), .zero_out(z8), .negative_out(n8), .div_zero(dz8)
  );

  alu_seq_unit #(.WIDTH(16)) u16 (
    .clk(clk), .reset_n(reset_n), .start(s16), .op(op16), .a(a16), .b(b16),
    .c_in(c16), .dec(dc16), .busy(busy16), .done(done16), .result(res16),
    .result_hi(hi16), .carry_out(co16), .half_carry_out(hc16),
    .overflow_out(v16), .zero_out(z16), .negative_out(n16), .div_zero(dz16)
  );

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic [15:0] hi;
    logic        c, v, z, n, dz, hc;
    bit          vchk, hcchk;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic last_dz8 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [15:0] r, input logic [15:0] h,
                              input logic c, input logic v, input logic z, input logic n,
                              input logic dz, input logic hc, input bit hcchk, input int lat);
    exp_t e;
    e.tag = tag; e.res = r; e.hi = h; e.c = c; e.v = v; e.z = z; e.n = n;
    e.dz = dz; e.hc = hc; e.vchk = 1'b1; e.hcchk = hcchk; e.lat = lat;
    return e;
  endfunction

  // Reference for binary-mode 8-bit ops, written from the arithmetic definitions.
  function automatic exp_t model8(input logic [3:0] opv, input logic [7:0] av, input logic [7:0] bv,
                                  input logic cv, input logic pdz);
    exp_t e;
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  nb;
    e.tag = $sformatf("rnd_op%0d_a%0h_b%0h", opv, av, bv);
    e.res = {8'h00, av}; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.hc = 1'b0;
    e.dz = pdz; e.vchk = 1'b1; e.hcchk = 1'b0; e.lat = 2;
    p = 16'(av) * 16'(bv);
    case (opv)
      4'd0: e.res = {8'h00, av | bv};
      4'd1: begin e.res = {8'h00, av & bv}; e.c = ((av & bv) != 8'h00); end
      4'd2: e.res = {8'h00, av ^ bv};
      4'd3: begin
        s = {1'b0, av} + {1'b0, bv} + 9'(cv);
        e.res = {8'h00, s[7:0]}; e.c = s[8];
        e.v = (av[7] == bv[7]) && (s[7] != av[7]);
        e.hc = (({1'b0, av[3:0]} + {1'b0, bv[3:0]} + 5'(cv)) > 5'd15); e.hcchk = 1'b1;
      end
      4'd4: begin
        nb = ~bv;
        s = {1'b0, av} + {1'b0, nb} + 9'(cv);
        e.res = {8'h00, s[7:0]}; e.c = s[8];
        e.v = (av[7] != bv[7]) && (s[7] != av[7]);
        e.hc = (({1'b0, av[3:0]} + {1'b0, nb[3:0]} + 5'(cv)) > 5'd15); e.hcchk = 1'b1;
      end
      4'd5: begin e.res = {8'h00, (av >> 1) | ({7'd0, cv} << 7)}; e.c = av[0]; e.vchk = 1'b0; end
      4'd6: begin e.res = {8'h00, (av << 1) | {7'd0, cv}}; e.c = av[7]; e.vchk = 1'b0; end
      4'd8: begin e.res = {8'h00, p[7:0]}; e.hi = {8'h00, p[15:8]}; e.lat = 10; end
      4'd9: begin
        e.vchk = 1'b0;
        if (bv == 8'h00) begin
          e.res = 16'h00FF; e.hi = {8'h00, av}; e.dz = 1'b1; e.c = 1'b1;
        end else begin
          e.res = {8'h00, av / bv}; e.hi = {8'h00, av % bv}; e.dz = 1'b0; e.lat = 10;
        end
      end
      default: e.vchk = 1'b0;
    endcase
    if (opv == 4'd8) begin
      e.z = (p == 16'h0000); e.n = p[15];
    end else begin
      e.z = (e.res[7:0] == 8'h00); e.n = e.res[7];
    end
    return e;
  endfunction

  task automatic run(input bit w16, input logic [3:0] opv, input logic [15:0] av,
                     input logic [15:0] bv, input logic cv, input logic dv,
                     input exp_t e, input int poke);
    int cyc, bcnt;
    logic dn;
    exp_t x;
    logic [15:0] r, h;
    logic fc, fv, fz, fn, fdz, fhc;
    sb.push_back(e);
    if (w16) begin
      op16 = opv; a16 = av; b16 = bv; c16 = cv; dc16 = dv; s16 = 1'b1;
    end else begin
      op8 = opv; a8 = av[7:0]; b8 = bv[7:0]; c8 = cv; dc8 = dv; s8 = 1'b1;
    end
    cyc = 0; bcnt = 0; dn = 1'b0;
    while (!dn && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin s8 = 1'b0; s16 = 1'b0; end
      if (poke > 0 && cyc == poke) begin op8 = OP_ORA; a8 = '0; b8 = '0; s8 = 1'b1; end
      if (poke > 0 && cyc == poke + 1) s8 = 1'b0;
      bcnt += int'(w16 ? busy16 : busy8);
      dn = w16 ? done16 : done8;
    end
    if (w16) begin
      r = res16; h = hi16; fc = co16; fv = v16; fz = z16; fn = n16; fdz = dz16; fhc = hc16;
    end else begin
      r = {8'h00, res8}; h = {8'h00, hi8}; fc = co8; fv = v8; fz = z8; fn = n8; fdz = dz8; fhc = hc8;
    end
    x = sb.pop_front();
    chk({x.tag, "_done"}, dn, 1);
    chk({x.tag, "_latency"}, cyc, x.lat);
    chk({x.tag, "_busy_cycles"}, bcnt, x.lat - 1);
    chk({x.tag, "_result"}, r, x.res);
    chk({x.tag, "_result_hi"}, h, x.hi);
    chk({x.tag, "_C"}, fc, x.c);
    chk({x.tag, "_Z"}, fz, x.z);
    chk({x.tag, "_N"}, fn, x.n);
    chk({x.tag, "_div_zero"}, fdz, x.dz);
    if (x.vchk) chk({x.tag, "_V"}, fv, x.v);
    if (x.hcchk) chk({x.tag, "_H"}, fhc, x.hc);
  endtask

  initial begin
    logic [3:0] opsel [11];
    exp_t e;
    logic [3:0] ro;
    logic [7:0] ra, rb;
    logic rc, seen;

    opsel = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd13};
    reset_n = 1'b0;
    s8 = 0; c8 = 0; dc8 = 0; op8 = '0; a8 = '0; b8 = '0;
    s16 = 0; c16 = 0; dc16 = 0; op16 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs8", {busy8, done8, res8, hi8, co8, hc8, v8, z8, n8, dz8}, 0);
    chk("reset_outputs16", {busy16, done16, res16, co16, hc16, v16, z16, n16, dz16}, 0);
    chk("reset_hi16", hi16, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run(0, OP_ADC, 16'h45, 16'h38, 0, 1, mk("adc_dec_45_38", 16'h83, 0, 0, 0, 0, 1, 0, 0, 1, 2), 0);
    run(0, OP_ADC, 16'h99, 16'h01, 0, 1, mk("adc_dec_99_01", 16'h00, 0, 1, 0, 1, 0, 0, 0, 1, 2), 0);
    run(0, OP_SBC, 16'h50, 16'h01, 1, 1, mk("sbc_dec_50_01", 16'h49, 0, 1, 0, 0, 0, 0, 0, 1, 2), 0);
    run(0, OP_SBC, 16'h00, 16'h01, 1, 1, mk("sbc_dec_00_01", 16'h99, 0, 0, 0, 0, 1, 0, 0, 1, 2), 0);
    run(0, OP_MUL, 16'hFF, 16'hFF, 0, 0, mk("mul_ff_ff", 16'h01, 16'hFE, 0, 0, 0, 1, 0, 0, 0, 10), 3);
    e = mk("div_200_7", 16'd28, 16'd4, 0, 0, 0, 0, 0, 0, 0, 10); e.vchk = 0;
    run(0, OP_DIV, 16'd200, 16'd7, 0, 0, e, 0);
    e = mk("div_5a_0", 16'hFF, 16'h5A, 1, 0, 0, 1, 1, 0, 0, 2); e.vchk = 0;
    run(0, OP_DIV, 16'h5A, 16'h00, 0, 0, e, 0);
    last_dz8 = 1'b1;

    repeat (3) @(negedge clk);
    chk("hold_result", res8, 8'hFF);
    chk("hold_div_zero", dz8, 1);
    chk("hold_done_low", done8, 0);

    run(1, OP_ADC, 16'h9999, 16'h0001, 0, 1, mk("w16_adc_dec_9999", 16'h0000, 0, 1, 0, 1, 0, 0, 0, 1, 2), 0);
    run(1, OP_ADC, 16'h7FFF, 16'h0001, 0, 0, mk("w16_adc_bin_7fff", 16'h8000, 0, 0, 1, 0, 1, 0, 1, 1, 2), 0);

    for (int i = 0; i < 16; i++) begin
      ro = opsel[$urandom_range(0, 10)];
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      e = model8(ro, ra, rb, rc, last_dz8);
      last_dz8 = e.dz;
      run(0, ro, {8'h00, ra}, {8'h00, rb}, rc, 1'($urandom_range(0, 1)) & (ro > 4'd4), e, 0);
    end

    op8 = OP_MUL; a8 = 8'h03; b8 = 8'h05; c8 = 0; dc8 = 0; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_outputs", {done8, res8, hi8, co8, hc8, v8, z8, n8, dz8}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | done8;
    end
    chk("abort_no_done", seen, 0);
    last_dz8 = 1'b0;

    e = mk("ror_after_abort", 16'h80, 0, 1, 0, 0, 1, 0, 0, 0, 2); e.vchk = 0;
    run(0, OP_ROR, 16'h01, 16'h00, 1, 0, e, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
